// File: rtl/par_width_fifo.sv
// Circular-buffer FIFO with asymmetric write/read widths: each accepted write pushes
// PAR_WRITE elements, each accepted read pops PAR_READ elements, dout is show-ahead.
module par_width_fifo #(
  parameter int SIZE      = 4,
  parameter int MEM_SIZE  = 5,
  parameter int PAR_WRITE = 2,
  parameter int PAR_READ  = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clear,
  input  logic                      wen,
  input  logic                      ren,
  input  logic [PAR_WRITE*SIZE-1:0] din,
  output logic [PAR_READ*SIZE-1:0]  dout,
  output logic                      full,
  output logic                      ready,
  output logic                      empty,
  output logic                      valid
);

  localparam int PW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int CW = $clog2(MEM_SIZE + 1);
  localparam logic [PW:0]   DEPTH   = (PW+1)'(MEM_SIZE);
  localparam logic [PW-1:0] WR_STEP = (PAR_WRITE == MEM_SIZE) ? '0 : PW'(PAR_WRITE);
  localparam logic [PW-1:0] RD_STEP = (PAR_READ == MEM_SIZE) ? '0 : PW'(PAR_READ);

  logic [SIZE-1:0] mem [0:MEM_SIZE-1];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            wr_acc;
  logic            rd_acc;

  // Both operands are below MEM_SIZE, so one conditional subtract is a full modulo.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr, input logic [PW-1:0] k);
    logic [PW:0] s;
    s = {1'b0, ptr} + {1'b0, k};
    if (s >= DEPTH) s = s - DEPTH;
    return s[PW-1:0];
  endfunction

  // Handshake: a write is taken on a rising edge when wen && ready, a read when
  // ren && valid; requests without the matching flag are silently dropped. Both
  // flags come from the pre-edge count, so one edge can take a read and a write.
  assign full   = count > CW'(MEM_SIZE - PAR_WRITE);
  assign ready  = ~full;
  assign empty  = count < CW'(PAR_READ);
  assign valid  = ~empty;
  assign wr_acc = wen && ready && !clear;
  assign rd_acc = ren && valid && !clear;

  always_comb begin
    dout = '0;
    for (int i = 0; i < PAR_READ; i++)
      dout[i*SIZE +: SIZE] = mem[wrap_add(rd_ptr, PW'(i))];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= '0;
    end else if (clear) begin
      // Flush only moves the bookkeeping; stale mem contents stay behind.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        for (int i = 0; i < PAR_WRITE; i++)
          mem[wrap_add(wr_ptr, PW'(i))] <= din[i*SIZE +: SIZE];
        wr_ptr <= wrap_add(wr_ptr, WR_STEP);
      end
      if (rd_acc) rd_ptr <= wrap_add(rd_ptr, RD_STEP);
      count <= count + (wr_acc ? CW'(PAR_WRITE) : CW'(0)) - (rd_acc ? CW'(PAR_READ) : CW'(0));
    end
  end

endmodule

// File: tb/tb_par_width_fifo.sv
// Bench for par_width_fifo: a default instance (5 deep, 2 in / 4 out) and a
// second instance (8 deep, 2 in / 2 out), each tracked by an element queue.
module tb_par_width_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic a_clear, a_wen, a_ren;
  logic [7:0]  a_din;
  logic [15:0] a_dout;
  logic a_full, a_ready, a_empty, a_valid;

  logic b_clear, b_wen, b_ren;
  logic [7:0] b_din;
  logic [7:0] b_dout;
  logic b_full, b_ready, b_empty, b_valid;

  logic [3:0] qa[$];
  logic [3:0] qb[$];
  int vectors = 0;
  int errors  = 0;

  par_width_fifo #(.SIZE(4), .MEM_SIZE(5), .PAR_WRITE(2), .PAR_READ(4)) u_dut_a (
    .clk(clk), .rstn(rstn), .clear(a_clear), .wen(a_wen), .ren(a_ren), .din(a_din),
    .dout(a_dout), .full(a_full), .ready(a_ready), .empty(a_empty), .valid(a_valid));

  par_width_fifo #(.SIZE(4), .MEM_SIZE(8), .PAR_WRITE(2), .PAR_READ(2)) u_dut_b (
    .clk(clk), .rstn(rstn), .clear(b_clear), .wen(b_wen), .ren(b_ren), .din(b_din),
    .dout(b_dout), .full(b_full), .ready(b_ready), .empty(b_empty), .valid(b_valid));

  // Expected flags packed as {full, ready, empty, valid}.
  function automatic logic [3:0] exp_a_flags();
    int n = qa.size();
    return {n + 2 > 5, n + 2 <= 5, n < 4, n >= 4};
  endfunction

  function automatic logic [15:0] exp_a_dout();
    logic [15:0] d = '0;
    for (int i = 0; i < 4; i++) if (i < qa.size()) d[i*4 +: 4] = qa[i];
    return d;
  endfunction

  function automatic logic [3:0] exp_b_flags();
    int n = qb.size();
    return {n + 2 > 8, n + 2 <= 8, n < 2, n >= 2};
  endfunction

  function automatic logic [7:0] exp_b_dout();
    logic [7:0] d = '0;
    for (int i = 0; i < 2; i++) if (i < qb.size()) d[i*4 +: 4] = qb[i];
    return d;
  endfunction

  // Drivers start at a negedge, cover one rising edge, and return at the next negedge.
  task automatic step_a(input logic clr, input logic w, input logic r, input logic [7:0] d);
    bit acc_w, acc_r;
    a_clear = clr; a_wen = w; a_ren = r; a_din = d;
    @(posedge clk);
    acc_w = w && (qa.size() + 2 <= 5);
    acc_r = r && (qa.size() >= 4);
    if (clr) qa.delete();
    else begin
      if (acc_r) for (int i = 0; i < 4; i++) void'(qa.pop_front());
      if (acc_w) begin qa.push_back(d[3:0]); qa.push_back(d[7:4]); end
    end
    @(negedge clk);
    a_clear = 1'b0; a_wen = 1'b0; a_ren = 1'b0;
  endtask

  task automatic step_b(input logic clr, input logic w, input logic r, input logic [7:0] d);
    bit acc_w, acc_r;
    b_clear = clr; b_wen = w; b_ren = r; b_din = d;
    @(posedge clk);
    acc_w = w && (qb.size() + 2 <= 8);
    acc_r = r && (qb.size() >= 2);
    if (clr) qb.delete();
    else begin
      if (acc_r) for (int i = 0; i < 2; i++) void'(qb.pop_front());
      if (acc_w) begin qb.push_back(d[3:0]); qb.push_back(d[7:4]); end
    end
    @(negedge clk);
    b_clear = 1'b0; b_wen = 1'b0; b_ren = 1'b0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    qa.delete(); qb.delete();
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({a_full, a_ready, a_empty, a_valid} !== 4'b0110) begin
      errors++; $display("FAIL reset_flags_a got %b exp 0110", {a_full, a_ready, a_empty, a_valid});
    end
    vectors++;
    if (a_dout !== 16'h0000) begin
      errors++; $display("FAIL reset_dout_a got %h exp 0000", a_dout);
    end
    vectors++;
    if ({b_full, b_ready, b_empty, b_valid} !== 4'b0110 || b_dout !== 8'h00) begin
      errors++; $display("FAIL reset_b got %b/%h exp 0110/00", {b_full, b_ready, b_empty, b_valid}, b_dout);
    end
  endtask

  task automatic test_fill();
    step_a(0, 1, 0, 8'h75);
    step_a(0, 1, 0, 8'h75);
    vectors++;
    if ({a_full, a_ready, a_empty, a_valid} !== exp_a_flags() || a_dout !== exp_a_dout()) begin
      errors++; $display("FAIL fill got %b/%h exp %b/%h", {a_full, a_ready, a_empty, a_valid}, a_dout, exp_a_flags(), exp_a_dout());
    end
    step_a(0, 1, 0, 8'hee);
    vectors++;
    if ({a_full, a_ready, a_empty, a_valid} !== exp_a_flags() || a_dout !== exp_a_dout()) begin
      errors++; $display("FAIL fill_ignored got %b/%h exp %b/%h", {a_full, a_ready, a_empty, a_valid}, a_dout, exp_a_flags(), exp_a_dout());
    end
  endtask

  task automatic test_drain_wrap();
    step_a(0, 0, 1, 8'h00);
    vectors++;
    if ({a_full, a_ready, a_empty, a_valid} !== exp_a_flags()) begin
      errors++; $display("FAIL drain_flags got %b exp %b", {a_full, a_ready, a_empty, a_valid}, exp_a_flags());
    end
    step_a(0, 0, 1, 8'h00);
    vectors++;
    if ({a_full, a_ready, a_empty, a_valid} !== exp_a_flags()) begin
      errors++; $display("FAIL read_while_empty got %b exp %b", {a_full, a_ready, a_empty, a_valid}, exp_a_flags());
    end
    step_a(0, 1, 0, 8'h21);
    step_a(0, 1, 0, 8'h43);
    vectors++;
    if (a_dout !== exp_a_dout() || !a_valid) begin
      errors++; $display("FAIL wrap_dout got %h valid %b exp %h valid 1", a_dout, a_valid, exp_a_dout());
    end
  endtask

  task automatic test_clear();
    step_a(1, 1, 0, 8'hff);
    vectors++;
    if ({a_full, a_ready, a_empty, a_valid} !== exp_a_flags()) begin
      errors++; $display("FAIL clear_flags got %b exp %b", {a_full, a_ready, a_empty, a_valid}, exp_a_flags());
    end
    step_a(0, 1, 0, 8'h65);
    step_a(0, 1, 0, 8'h87);
    vectors++;
    if (a_dout !== exp_a_dout() || !a_valid) begin
      errors++; $display("FAIL clear_refill got %h exp %h", a_dout, exp_a_dout());
    end
  endtask

  task automatic test_simultaneous();
    step_b(0, 1, 0, 8'h10);
    step_b(0, 1, 0, 8'h32);
    step_b(0, 1, 1, 8'h54);
    vectors++;
    if ({b_full, b_ready, b_empty, b_valid} !== exp_b_flags() || qb.size() != 4 || b_dout !== exp_b_dout()) begin
      errors++; $display("FAIL simul got %b/%h exp %b/%h", {b_full, b_ready, b_empty, b_valid}, b_dout, exp_b_flags(), exp_b_dout());
    end
    for (int k = 0; k < 3; k++) begin
      step_b(0, 0, 1, 8'h00);
      vectors++;
      if ({b_full, b_ready, b_empty, b_valid} !== exp_b_flags() || (b_valid && b_dout !== exp_b_dout())) begin
        errors++; $display("FAIL simul_drain%0d got %b/%h exp %b/%h", k, {b_full, b_ready, b_empty, b_valid}, b_dout, exp_b_flags(), exp_b_dout());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++) begin
      step_a($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, 8'($urandom));
      vectors++;
      if ({a_full, a_ready, a_empty, a_valid} !== exp_a_flags() || (a_valid && a_dout !== exp_a_dout())) begin
        errors++; $display("FAIL rand_a%0d got %b/%h exp %b/%h", k, {a_full, a_ready, a_empty, a_valid}, a_dout, exp_a_flags(), exp_a_dout());
      end
      step_b($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, 8'($urandom));
      vectors++;
      if ({b_full, b_ready, b_empty, b_valid} !== exp_b_flags() || (b_valid && b_dout !== exp_b_dout())) begin
        errors++; $display("FAIL rand_b%0d got %b/%h exp %b/%h", k, {b_full, b_ready, b_empty, b_valid}, b_dout, exp_b_flags(), exp_b_dout());
      end
    end
  endtask

  task automatic test_async_reset();
    step_a(0, 1, 0, 8'h9a);
    step_a(0, 1, 0, 8'hbc);
    step_b(0, 1, 0, 8'hde);
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if ({a_full, a_ready, a_empty, a_valid} !== 4'b0110 || a_dout !== 16'h0000) begin
      errors++; $display("FAIL async_rst_a got %b/%h exp 0110/0000", {a_full, a_ready, a_empty, a_valid}, a_dout);
    end
    vectors++;
    if ({b_full, b_ready, b_empty, b_valid} !== 4'b0110 || b_dout !== 8'h00) begin
      errors++; $display("FAIL async_rst_b got %b/%h exp 0110/00", {b_full, b_ready, b_empty, b_valid}, b_dout);
    end
    qa.delete(); qb.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    step_a(0, 1, 0, 8'h13);
    step_a(0, 1, 0, 8'h57);
    vectors++;
    if (a_dout !== exp_a_dout() || !a_valid) begin
      errors++; $display("FAIL post_rst_a got %h exp %h", a_dout, exp_a_dout());
    end
  endtask

  initial begin
    rstn = 1'b0;
    a_clear = 1'b0; a_wen = 1'b0; a_ren = 1'b0; a_din = '0;
    b_clear = 1'b0; b_wen = 1'b0; b_ren = 1'b0; b_din = '0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain_wrap();
    test_clear();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
